// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - register file debug dump engine, byte-serial 5-byte records per selected register
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       mask,
    output logic [4:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [31:0]       mask_q, mask_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              higher_set;
    logic              xfer;

    // Any selected register above the current index still pending?
    always_comb begin
        higher_set = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i > int'(idx_q) && mask_q[i]) begin
                higher_set = 1'b1;
            end
        end
    end

    assign out_valid = (state_q == S_SEND);
    assign xfer      = out_valid && out_ready;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign rd_addr   = idx_q;
    assign out_last  = out_valid && (cnt_q == 3'd4) && !higher_set;

    // Byte mux is driven only by registers, so it holds steady under backpressure.
    always_comb begin
        out_data = 8'h00;
        if (state_q == S_SEND) begin
            case (cnt_q)
                3'd0:    out_data = {3'b000, idx_q};
                3'd1:    out_data = hold_q[7:0];
                3'd2:    out_data = hold_q[15:8];
                3'd3:    out_data = hold_q[23:16];
                default: out_data = hold_q[31:24];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = mask;
                    idx_d   = 5'd0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (mask_q[idx_q]) begin
                    hold_d  = rd_data;
                    cnt_d   = 3'd0;
                    state_d = S_SEND;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (cnt_q == 3'd4) begin
                        if (idx_q == LAST_IDX || !higher_set) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            state_d = S_SCAN;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                idx_d   = 5'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            mask_q  <= 32'd0;
            hold_q  <= '0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - scoreboard bench for regfile_dump with randomized masks, data and backpressure
module tb_regfile_dump;

    localparam int NREGS = 32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] mask;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [NREGS];
    logic [8:0]  sb [$];
    int          cyc = 0;
    int          cmps = 0;
    int          errs = 0;
    bit          ready_rnd = 1'b0;

    bit          stall_q = 1'b0;
    logic [7:0]  pd;
    logic        pl;

    regfile_dump #(.NUM_REGS(NREGS), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mask      (mask),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    assign rd_data = (rd_addr == 5'd0) ? 32'd0 : regs[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] regval(input int i);
        return (i == 0) ? 32'd0 : regs[i];
    endfunction

    // Reference: each selected register, in index order, yields index byte then data LSB first.
    task automatic push_expected(input logic [31:0] m, input int hi);
        logic [31:0] v;
        for (int i = 0; i < NREGS; i++) begin
            if (m[i]) begin
                v = regval(i);
                sb.push_back({1'b0, 8'(i)});
                for (int b = 0; b < 4; b++)
                    sb.push_back({(i == hi && b == 3), v[8*b +: 8]});
            end
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q)
                chk("stall_hold", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, pl, pd});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    cmps++;
                    errs++;
                    $display("FAIL unexpected_byte: got 0x%0h expected no byte", {out_last, out_data});
                end else begin
                    e = sb.pop_front();
                    chk("stream_byte", {23'd0, out_last, out_data}, {23'd0, e});
                end
            end
            stall_q = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ctrl"}, {28'd0, out_valid, out_last, busy, done}, 32'd0);
        chk({tag, "_data"}, {24'd0, out_data}, 32'd0);
        chk({tag, "_addr"}, {27'd0, rd_addr}, 32'd0);
    endtask

    task automatic run_dump(input logic [31:0] m, input bit rnd, input bit inj, input bit wr5);
        int lo, hi, pc, s, nx, fv, lc, dc;
        bit wrote;
        lo = -1; hi = -1; pc = 0;
        for (int i = 0; i < NREGS; i++)
            if (m[i]) begin
                if (lo < 0) lo = i;
                hi = i;
                pc++;
            end
        push_expected(m, hi);
        ready_rnd = rnd;
        @(posedge clk); #1;
        mask = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mask = $urandom;
        s = cyc;
        fv = -1; lc = -1; dc = -1; nx = 0; wrote = 1'b0;
        for (int k = 0; k < 4000 && dc < 0; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_running", {31'd0, busy}, 32'd1);
            if (inj && k == 3) begin
                mask = 32'hF;
                start = 1'b1;
            end
            if (inj && k == 4) start = 1'b0;
            if (out_valid && fv < 0) fv = cyc - s + 1;
            if (out_valid && out_ready) begin
                nx++;
                if (out_last) lc = cyc - s + 1;
            end
            if (wr5 && !wrote && out_valid) begin
                regs[5] = ~regs[5];
                wrote = 1'b1;
            end
            if (done) dc = cyc - s + 1;
        end
        start = 1'b0;
        if (dc < 0) begin
            cmps++;
            errs++;
            $display("FAIL done_timeout: got no done expected done within bound");
        end
        chk("xfer_count", nx, 5 * pc);
        if (pc == 0) chk("done_cycle_empty", dc, NREGS + 1);
        else chk("done_after_last", dc, lc + 1);
        if (!rnd && pc > 0) begin
            chk("first_valid_cycle", fv, lo + 2);
            chk("last_byte_cycle", lc, hi + 1 + 5 * pc);
        end
        chk("sb_drained", sb.size(), 0);
        @(negedge clk);
        chk("idle_after_done", {30'd0, busy, done}, 32'd0);
        sb.delete();
    endtask

    task automatic reset_mid_send();
        bit seen;
        seen = 1'b0;
        ready_rnd = 1'b0;
        push_expected(32'hFFFF_FFFF, 31);
        @(posedge clk); #1;
        mask = 32'hFFFF_FFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("valid_before_reset", {31'd0, out_valid}, 32'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outs("reset_mid_send");
        start = 1'b1;
        mask = 32'h0000_000F;
        @(posedge clk); #1;
        start = 1'b0;
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ignored", {30'd0, busy, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] m;
        rst = 1'b0;
        start = 1'b0;
        mask = 32'd0;
        for (int i = 0; i < NREGS; i++) regs[i] = 32'h1111_0000 + i;
        regs[0] = 32'd0;

        #2 rst = 1'b1;
        #1 chk_reset_outs("reset_initial");
        @(posedge clk); #1;
        start = 1'b1;
        mask = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ignored", {30'd0, busy, out_valid}, 32'd0);

        regs[3] = 32'hDEAD_BEEF;
        run_dump(32'h0000_0008, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < NREGS; i++) regs[i] = 32'h1111_0000 + i;
        regs[0] = 32'd0;
        run_dump(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_dump(32'h8000_0011, 1'b1, 1'b0, 1'b0);
        run_dump(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        run_dump(32'h0000_0000, 1'b1, 1'b0, 1'b0);
        run_dump(32'h0001_0100, 1'b0, 1'b1, 1'b0);
        regs[5] = 32'hA5A5_0505;
        run_dump(32'h0000_0020, 1'b0, 1'b0, 1'b1);

        reset_mid_send();
        run_dump(32'h4000_0005, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
            m = $urandom & $urandom;
            if (t == 0) m = 32'h0000_0001;
            run_dump(m, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the single-cycle RISC-V core's 32-entry register file. On a start pulse it walks the register file through a dedicated read port and streams each selected register out as a byte-serial record on a valid/ready interface. A test harness or UART bridge uses these records to observe architectural state without simulator `$display`. It is the reading counterpart to the core's register write port: it only reads and never modifies register contents.

## Interface
- `NUM_REGS`, default 32: number of registers scanned; indices 0..NUM_REGS-1.
- `DATA_W`, default 32: register width; fixed at 32 for the 5-byte record format.
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle request to begin a dump; sampled only in IDLE.
- `mask`  in  32  register select; bit i set means register i is dumped; latched on an accepted `start`.
- `rd_addr`  out  5  register file read address.
- `rd_data`  in  32  register file read data; combinational from `rd_addr`.
- `out_valid`  out  1  byte available.
- `out_ready`  in  1  sink accepts the byte.
- `out_data`  out  8  stream byte.
- `out_last`  out  1  marks the final byte of the final record.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse when the dump completes.

## Operation
- States: IDLE, SCAN, SEND, DONE.
- **IDLE**
  - `start`=1: latch `mask`, set idx=0, go to SCAN.
  - Otherwise remain in IDLE.
- **SCAN**
  - `rd_addr`=idx.
  - If mask[idx]=1: capture `rd_data` into a 32-bit hold register, clear the byte counter, go to SEND.
  - Else if idx=NUM_REGS-1: go to DONE.
  - Else: idx+1 and stay in SCAN.
  - Each SCAN cycle tests exactly one index.
- **SEND**
  - Record format: byte0 = {3'b000, idx[4:0]}, bytes 1..4 = captured data, least significant byte first.
  - A byte transfers on `out_valid && out_ready`.
  - The byte counter advances 0..4 on each transfer.
  - After byte 4 transfers: if idx=NUM_REGS-1 or no higher mask bit is set, go to DONE; otherwise idx+1 and go to SCAN.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- The record holds a snapshot taken at the SCAN capture edge. Register writes after that edge do not alter the record.
- Register 0 is dumped like any other register; its data reads as 0.
- `out_last`=1 only on byte 4 of a record with no higher mask bit set.
- mask=0: the dump emits no bytes; the state sequence is SCAN (all indices) then DONE.
- `start` while not in IDLE is ignored; the latched mask is unchanged.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0, `rd_addr`=0, idx=0.
- Reset asserted mid-dump forces these values immediately, without waiting for a clock edge. The partial record is abandoned and not resumed.
- `busy`=1 in SCAN, SEND and DONE; `busy`=0 in IDLE.
- Start latency: `start` sampled at edge 0. SCAN of idx 0 runs in cycle 1. If mask[0]=1, `out_valid` rises in cycle 2.
- Throughput: each skipped index costs 1 cycle. Each dumped register costs 1 SCAN cycle plus 5 transfer cycles when `out_ready` is held at 1.
- Full mask with `out_ready`=1: 192 cycles from the first SCAN cycle through the last byte; `done` follows in the next cycle.
- Stream stability: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold steady.
- `out_valid` never drops without a transfer, except on reset.
- `out_valid` is registered; it does not depend combinationally on `out_ready`.
- `done` pulses in the cycle after the final byte transfers, or the cycle after the final SCAN when no bytes are sent. The block is back in IDLE one cycle later and can accept `start` there.

## Test plan
- **Reset:** assert `rst` asynchronously between clock edges → all outputs go to 0 immediately; `start` pulses while `rst`=1 are ignored.
- **Single register:** reg3=0xDEADBEEF, mask=0x00000008, `out_ready`=1 → bytes 03 EF BE AD DE; `out_last` set only on DE; `done` pulses one cycle after DE; `busy` deasserts with return to IDLE.
- **Full dump:** regs i=0x11110000+i (reg0=0), mask=0xFFFFFFFF, `out_ready`=1 → 160 bytes in index order; exactly one `out_last`, on byte 160; 192 cycles from first SCAN to last byte.
- **Backpressure:** mask=0x80000011, `out_ready` random at 50% → `out_data`/`out_last` stable during stalls; records for 0, 4, 31; `out_last` set on reg31's byte 4; sink byte count is 15.
- **Empty mask:** mask=0 → `out_valid` never asserts; `done` pulses 33 cycles after the `start` edge (32 SCAN cycles then DONE).
- **Protocol edges:**
  - `start` with mask=0xF while busy → ignored; the output matches the original mask.
  - Write reg5 after its capture edge → the record carries the old value.
  - `rst` mid-SEND → `out_valid`=0 immediately; a new `start` produces a clean dump from idx 0.
